// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: iterative 32-cycle multiply/divide unit owning the HI/LO register pair.
module hi_lo_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);
  localparam int W = DATA_WIDTH;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, acc_q, acc_d, sh_q, sh_d, m_q, m_d;
  logic div_q, div_d, negq_q, negq_d, negr_q, negr_d, done_q, done_d;
  logic md, sa, sb;
  logic [W-1:0] mag_a, mag_b, quo_c, rem_c, fin_hi, fin_lo;
  logic [W:0] mul_sum, div_sh, div_diff;
  logic [2*W-1:0] prod, prod_c;
  assign md       = funct[5:2] == 4'b0110;
  assign sa       = ~funct[0] & operand_a[W-1];
  assign sb       = ~funct[0] & operand_b[W-1];
  assign mag_a    = sa ? -operand_a : operand_a;
  assign mag_b    = sb ? -operand_b : operand_b;
  // acc holds the running high half (multiply) or partial remainder (divide); sh the low half / quotient
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
  assign div_sh   = {acc_q, sh_q[W-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign prod     = {acc_q, sh_q};
  assign prod_c   = negq_q ? -prod : prod;
  assign quo_c    = negq_q ? -sh_q : sh_q;
  assign rem_c    = negr_q ? -acc_q : acc_q;
  // divide-by-zero: remainder already equals the dividend, only the quotient needs forcing
  assign fin_hi   = div_q ? rem_c : prod_c[2*W-1:W];
  assign fin_lo   = div_q ? (m_q == '0 ? '1 : quo_c) : prod_c[W-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    m_d     = m_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && md) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = funct[1];
          negq_d  = sa ^ sb;
          negr_d  = sa;
          acc_d   = '0;
          sh_d    = funct[1] ? mag_a : mag_b;
          m_d     = funct[1] ? mag_b : mag_a;
        end
        hi_d = (start && funct == F_MTHI) ? operand_a : hi_q;
        lo_d = (start && funct == F_MTLO) ? operand_a : lo_q;
      end
      RUN: begin
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'd31 ? FINISH : RUN;
        acc_d   = div_q ? (div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0]) : mul_sum[W:1];
        sh_d    = div_q ? {sh_q[W-2:0], ~div_diff[W]} : {mul_sum[0], sh_q[W-1:1]};
      end
      FINISH: begin
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      m_q     <= m_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: doc/hi_lo_muldiv_unit.md
HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request strobe, driven by the decoder's HI_register_write.
REQ-006 Port: funct  input  6  R-type funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
REQ-007 Port: operand_a  input  32  rs value (multiplicand / dividend / mthi-mtlo source).
REQ-008 Port: operand_b  input  32  rt value (multiplier / divisor).
REQ-009 Port: busy  output  1  high while a mult/div is in progress; the pipeline stalls on it.
REQ-010 Port: done  output  1  one-cycle pulse when HI/LO are updated by mult/div.
REQ-011 Port: hi_out  output  32  current HI register, read by mfhi.
REQ-012 Port: lo_out  output  32  current LO register, read by mflo.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and FINISH, and SHALL encode them in a 2-bit register.
REQ-014 In IDLE, start=1 with a mult/multu/div/divu funct SHALL latch the operands, clear a 6-bit cycle counter and move to RUN at that edge (edge k).
REQ-015 In IDLE, start=1 with mthi/mtlo SHALL write operand_a to HI/LO at that edge, stay in IDLE, leave busy low and leave done low.
REQ-016 In IDLE, start=1 with any other funct SHALL be ignored.
REQ-017 Signed operations SHALL operate on operand magnitudes; signs SHALL be recorded at edge k.
REQ-018 RUN SHALL last exactly 32 edges and process one bit per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-019 After the 32nd RUN edge the FSM SHALL enter FINISH.
REQ-020 FINISH SHALL apply the sign correction and write HI/LO at edge k+33, then return to IDLE.
REQ-021 Sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-022 mult/multu: HI SHALL be product[63:32] and LO product[31:0], two's-complement (signed) or unsigned.
REQ-023 div/divu: LO SHALL be the quotient and HI the remainder, truncating toward zero.
REQ-024 Divide by zero (div or divu): LO SHALL be 0xFFFFFFFF, HI SHALL be operand_a unchanged, and the block SHALL still take full latency.
REQ-025 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no exception.
REQ-026 busy SHALL be high in RUN and FINISH, going high after edge k and low after edge k+33.
REQ-027 done SHALL be registered, high for exactly the one cycle after edge k+33.
REQ-028 start while busy SHALL be ignored and SHALL NOT disturb the operation or HI/LO.
REQ-029 HI/LO SHALL hold their values while in RUN; intermediate results SHALL NOT be visible on hi_out/lo_out.
REQ-030 A new start SHALL be accepted in the cycle done is high; back-to-back throughput is one op per 34 cycles.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, counter 0, busy 0, done 0, HI 0, LO 0, working registers 0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no partial HI/LO write.
REQ-033 After reset_n deasserts, the first rising edge SHALL accept a new start.

Verification
REQ-034 mult 0xFFFFFFFD(-3) x 0x00000005 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; done pulses once.
REQ-035 multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 div 0xFFFFFFF9(-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 divu 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, with busy high for 33 cycles.
REQ-038 Second start (mult 2x2) at cycle 10 of a divu 100/7 -> ignored; result is LO=14, HI=2, then a start in the done cycle is accepted.
REQ-039 mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> hi_out/lo_out update the next cycle with busy and done low; reset_n low at cycle 15 of a mult -> HI=LO=0, busy 0, and no done.
